// File: rtl/hbridge_gate_sequencer.sv
// H-bridge gate-drive sequencer: bootstrap pre-charge, per-leg dead time,
// shoot-through fault latch and orderly shutdown on the control clock.
module hbridge_gate_sequencer #(
  parameter int DT_WIDTH    = 10,
  parameter int BOOT_CYCLES = 1000
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic                i_enable,
  input  logic [3:0]          i_MOSFET,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  input  logic                i_fault_clear,
  output logic [3:0]          o_Q,
  output logic [1:0]          o_state,
  output logic                o_on,
  output logic                o_fault
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  // Both low-side switches on: charges the bootstrap capacitors.
  localparam logic [3:0] Q_PRECHARGE = 4'b1100;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_PRECHARGE = 2'b01,
    ST_RUN       = 2'b10,
    ST_FAULT     = 2'b11
  } state_t;

  // Per-leg drive is {high, low}; 11 is never applied.
  typedef struct packed {
    logic [1:0]          drive;
    logic [DT_WIDTH-1:0] cnt;
  } leg_t;

  state_t              state_q, state_d;
  logic [3:0]          q_q, q_d;
  logic [BOOT_W-1:0]   boot_q, boot_d;
  logic [DT_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                on_q, fault_q;

  logic [1:0] req_a, req_b, app_a, app_b;
  logic       illegal;
  leg_t       step_a, step_b;

  // One dead-time step for a leg. Any departure from a non-off drive first
  // forces 00 and loads the dead time; the new request is only applied once
  // the counter has run out, so a bounced request still waits the full gap.
  function automatic leg_t leg_step(input logic [1:0]          req,
                                    input logic [1:0]          app,
                                    input logic [DT_WIDTH-1:0] cnt,
                                    input logic [DT_WIDTH-1:0] dt);
    leg_t nxt;
    nxt.drive = app;
    nxt.cnt   = cnt;
    if (req == app) begin
      if (cnt != '0) nxt.cnt = cnt - DT_WIDTH'(1);
    end else if (app != 2'b00) begin
      nxt.drive = 2'b00;
      nxt.cnt   = dt;
    end else if (cnt != '0) begin
      nxt.cnt = cnt - DT_WIDTH'(1);
    end else begin
      nxt.drive = req;
    end
    return nxt;
  endfunction

  assign req_a   = {i_MOSFET[0], i_MOSFET[2]};
  assign req_b   = {i_MOSFET[1], i_MOSFET[3]};
  assign app_a   = {q_q[0], q_q[2]};
  assign app_b   = {q_q[1], q_q[3]};
  assign illegal = (req_a == 2'b11) || (req_b == 2'b11);

  assign step_a = leg_step(req_a, app_a, cnt_a_q, i_deadtime);
  assign step_b = leg_step(req_b, app_b, cnt_b_q, i_deadtime);

  always_comb begin
    state_d = state_q;
    q_d     = 4'b0000;
    boot_d  = '0;
    cnt_a_d = '0;
    cnt_b_d = '0;
    case (state_q)
      ST_OFF: begin
        if (i_enable) begin
          state_d = ST_PRECHARGE;
          q_d     = Q_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        if (!i_enable) begin
          state_d = ST_OFF;
        end else begin
          // Legs enter RUN low-side on, which is the pre-charge pattern.
          q_d = Q_PRECHARGE;
          if (boot_q == BOOT_LAST) state_d = ST_RUN;
          else                     boot_d  = boot_q + BOOT_W'(1);
        end
      end
      ST_RUN: begin
        // An illegal request outranks an enable drop on the same cycle.
        if (illegal) begin
          state_d = ST_FAULT;
        end else if (!i_enable) begin
          state_d = ST_OFF;
        end else begin
          q_d     = {step_b.drive[0], step_a.drive[0],
                     step_b.drive[1], step_a.drive[1]};
          cnt_a_d = step_a.cnt;
          cnt_b_d = step_b.cnt;
        end
      end
      ST_FAULT: begin
        if (i_fault_clear && !i_enable) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q <= ST_OFF;
      q_q     <= 4'b0000;
      boot_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      on_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      boot_q  <= boot_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      on_q    <= (state_d == ST_RUN);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign o_Q     = q_q;
  assign o_state = state_q;
  assign o_on    = on_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// Self-checking bench for hbridge_gate_sequencer: directed scenarios plus
// randomized requests against a time-based behavioural model.
module tb_hbridge_gate_sequencer;

  localparam int DT_WIDTH = 10;
  localparam int BOOT     = 1000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [3:0]          mos;
  logic [DT_WIDTH-1:0] dt;
  logic                clr;
  logic [3:0]          q;
  logic [1:0]          st;
  logic                on;
  logic                flt;

  always #5 clk = ~clk;

  hbridge_gate_sequencer #(.DT_WIDTH(DT_WIDTH), .BOOT_CYCLES(BOOT)) dut (
    .i_clock      (clk),
    .i_RESET      (rst_n),
    .i_enable     (en),
    .i_MOSFET     (mos),
    .i_deadtime   (dt),
    .i_fault_clear(clr),
    .o_Q          (q),
    .o_state      (st),
    .o_on         (on),
    .o_fault      (flt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  // Model: states as numbers, legs as applied value plus the cycle index
  // from which a new non-off value may be applied.
  int         cyc = 0;
  logic [1:0] m_state;
  logic [1:0] m_a, m_b;
  int         rdy_a, rdy_b;
  int         pre_start;
  logic [3:0] prev_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_a = 2'b00;
    m_b = 2'b00;
    rdy_a = 0;
    rdy_b = 0;
    pre_start = 0;
    prev_q = 4'b0000;
    exp_q.delete();
  endtask

  function automatic void leg_model(input logic [1:0] req, input logic [1:0] app_in,
                                    input int rdy_in, input int n, input int d,
                                    output logic [1:0] app_out, output int rdy_out);
    app_out = app_in;
    rdy_out = rdy_in;
    if (req != app_in) begin
      if (app_in != 2'b00) begin
        app_out = 2'b00;
        rdy_out = n + 1 + d;
      end else if (n >= rdy_in) begin
        app_out = req;
      end
    end
  endfunction

  task automatic model_step();
    logic [1:0] ra, rb, na, nb;
    int         qa, qb;
    logic [3:0] mq;
    ra = {mos[0], mos[2]};
    rb = {mos[1], mos[3]};
    case (m_state)
      2'd0: if (en) begin m_state = 2'd1; pre_start = cyc + 1; end
      2'd1: begin
        if (!en) m_state = 2'd0;
        else if (cyc - pre_start == BOOT - 1) begin
          m_state = 2'd2;
          m_a = 2'b01;
          m_b = 2'b01;
          rdy_a = cyc;
          rdy_b = cyc;
        end
      end
      2'd2: begin
        if (ra == 2'b11 || rb == 2'b11) m_state = 2'd3;
        else if (!en) m_state = 2'd0;
        else begin
          leg_model(ra, m_a, rdy_a, cyc, int'(dt), na, qa);
          leg_model(rb, m_b, rdy_b, cyc, int'(dt), nb, qb);
          m_a = na; rdy_a = qa;
          m_b = nb; rdy_b = qb;
        end
      end
      default: if (clr && !en) m_state = 2'd0;
    endcase
    case (m_state)
      2'd1:    mq = 4'b1100;
      2'd2:    mq = {m_b[0], m_a[0], m_b[1], m_a[1]};
      default: mq = 4'b0000;
    endcase
    exp_q.push_back({m_state, mq});
    cyc++;
  endtask

  // Inputs are stable here; the model consumes them, then the edge happens
  // and outputs are compared on the following falling edge.
  task automatic tick();
    logic [5:0] e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("state", 32'(st), 32'(e[5:4]));
      check("q", 32'(q), 32'(e[3:0]));
      check("on", 32'(on), 32'(e[5:4] == 2'd2));
      check("fault", 32'(flt), 32'(e[5:4] == 2'd3));
    end
    check("leg_exclusive", 32'({q[0] & q[2], q[1] & q[3]}), 32'd0);
    check("leg_a_gap", 32'(({prev_q[0], prev_q[2]} != 2'b00) && ({q[0], q[2]} != 2'b00) &&
                           ({prev_q[0], prev_q[2]} != {q[0], q[2]})), 32'd0);
    check("leg_b_gap", 32'(({prev_q[1], prev_q[3]} != 2'b00) && ({q[1], q[3]} != 2'b00) &&
                           ({prev_q[1], prev_q[3]} != {q[1], q[3]})), 32'd0);
    prev_q = q;
  endtask

  task automatic drive(input logic e, input logic [3:0] m, input int d, input logic c);
    en  = e;
    mos = m;
    dt  = DT_WIDTH'(d);
    clr = c;
  endtask

  function automatic logic [1:0] rand_leg();
    if ($urandom_range(0, 299) == 0) return 2'b11;
    return 2'($urandom_range(0, 2));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, off_a, high_a;
    logic [1:0] la, lb;
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_q", 32'(q), 32'd0);
    check("reset_state", 32'(st), 32'd0);
    check("reset_on", 32'(on), 32'd0);
    check("reset_fault", 32'(flt), 32'd0);
    rst_n = 1'b1;

    // OFF ignores requests
    repeat (5) begin mos = 4'($urandom_range(0, 15)); tick(); end

    // Enable and full pre-charge
    drive(1'b1, 4'b1100, 0, 1'b0);
    cnt = 0;
    for (int i = 0; i < BOOT + 2; i++) begin
      tick();
      if (st == 2'b01 && q == 4'b1100) cnt++;
    end
    check("boot_len", 32'(cnt), 32'(BOOT));
    check("boot_run_on", 32'(on), 32'd1);

    // Both legs low->high with dead time 10
    drive(1'b1, 4'b1100, 10, 1'b0);
    repeat (3) tick();
    mos = 4'b0011;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (q == 4'b0000) cnt++; end
    check("dt10_off_cycles", 32'(cnt), 32'd11);
    check("dt10_final", 32'(q), 32'b0011);

    // Dead time 0 still gives one off cycle
    drive(1'b1, 4'b1100, 0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (q == 4'b0000) cnt++; end
    check("dt0_off_cycles", 32'(cnt), 32'd1);
    check("dt0_final", 32'(q), 32'b1100);

    // Leg A bounces 01->10->01 within the dead time
    drive(1'b1, 4'b1001, 10, 1'b0);
    off_a = 0;
    high_a = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) mos = 4'b1100;
      tick();
      if ({q[0], q[2]} == 2'b00) off_a++;
      if (q[0]) high_a++;
    end
    check("bounce_off_cycles", 32'(off_a), 32'd11);
    check("bounce_no_high", 32'(high_a), 32'd0);
    check("bounce_final", 32'(q), 32'b1100);

    // Shoot-through request latches a fault
    mos = 4'b0101;
    tick();
    check("fault_entry_state", 32'(st), 32'd3);
    check("fault_entry_q", 32'(q), 32'd0);
    drive(1'b1, 4'b1100, 10, 1'b1);
    repeat (4) tick();
    check("fault_clear_ignored", 32'(st), 32'd3);
    drive(1'b0, 4'b1100, 10, 1'b0);
    repeat (2) tick();
    check("fault_held", 32'(flt), 32'd1);
    clr = 1'b1;
    tick();
    check("fault_exit", 32'(st), 32'd0);
    clr = 1'b0;

    // Enable drop in the middle of pre-charge, then a full pre-charge again
    en = 1'b1;
    repeat (501) tick();
    en = 1'b0;
    tick();
    check("abort_state", 32'(st), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < BOOT + 2; i++) begin
      tick();
      if (st == 2'b01) cnt++;
    end
    check("reboot_len", 32'(cnt), 32'(BOOT));

    // Randomized requests, dead times, enable drops and fault clears
    la = 2'b01;
    lb = 2'b01;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) la = rand_leg();
      if ($urandom_range(0, 3) == 0) lb = rand_leg();
      mos = {lb[0], la[0], lb[1], la[1]};
      if ($urandom_range(0, 49) == 0) dt = DT_WIDTH'($urandom_range(0, 12));
      if (m_state == 2'd3) en = 1'($urandom_range(0, 1));
      else                 en = ($urandom_range(0, 399) != 0);
      clr = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a dead-time interval
    drive(1'b1, 4'b1100, 10, 1'b0);
    for (int i = 0; i < 2 * BOOT + 10 && m_state != 2'd2; i++) tick();
    check("pre_reset_run", 32'(st), 32'd2);
    repeat (2) tick();
    mos = 4'b0011;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", 32'(q), 32'd0);
    check("async_state", 32'(st), 32'd0);
    check("async_on", 32'(on), 32'd0);
    check("async_fault", 32'(flt), 32'd0);
    model_reset();
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
